// File: rtl/i2s_tx_10xe_aud_pkg.sv
// i2s_tx_10xe_aud_pkg: shared field positions, FSM states and stereo-pair type for the audio receive stage
package i2s_tx_10xe_aud_pkg;
    localparam int SMP_LSB       = 4;
    localparam int SMP_MSB       = 27;
    localparam int PAR_BIT       = 31;
    localparam int TID_RIGHT_BIT = 0;
    typedef enum logic {WAIT_L, WAIT_R} aud_rx_state_e;
    typedef struct packed {logic [23:0] l, r;} aud_pair_t;
endpackage

// File: rtl/i2s_tx_10xe_pair_fifo.sv
// i2s_tx_10xe_pair_fifo: synchronous first-word-fall-through FIFO of stereo pairs
// When empty the output holds the last popped pair (zero after reset or flush).
module i2s_tx_10xe_pair_fifo
    import i2s_tx_10xe_aud_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  aud_pair_t              pair_i,
    input  logic                   pop_i,
    output aud_pair_t              pair_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    aud_pair_t     mem_q [DEPTH];
    aud_pair_t     last_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign level_o = level_q;
    assign pair_o  = empty_o ? last_q : mem_q[rd_q];
    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            last_q  <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) begin
                rd_q   <= rd_q + AW'(1);
                last_q <= mem_q[rd_q];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= pair_i;
    end
endmodule

// File: rtl/i2s_tx_10xe_aud_stream_rx.sv
// i2s_tx_10xe_aud_stream_rx: AXI-Stream audio receive, L/R pairing for one channel pair, pair FIFO
// Optional parity check with zeroing of bad samples: define I2S_TX_10XE_PARITY_CHECK_EN.
module i2s_tx_10xe_aud_stream_rx
    import i2s_tx_10xe_aud_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SMP_W      = 24
) (
    input  logic                        s_axis_aud_aclk,
    input  logic                        s_axis_aud_aresetn,
    input  logic [31:0]                 s_axis_aud_tdata,
    input  logic [2:0]                  s_axis_aud_tid,
    input  logic                        s_axis_aud_tvalid,
    output logic                        s_axis_aud_tready,
    input  logic                        aud_en,
    input  logic [1:0]                  cfg_pair,
    output logic                        smp_valid,
    input  logic                        smp_ready,
    output logic [SMP_W-1:0]            smp_left,
    output logic [SMP_W-1:0]            smp_right,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ch_err,
    output logic                        par_err
);
    aud_rx_state_e    state_q, state_d;
    logic [SMP_W-1:0] left_q, left_d, smp, smp_chk;
    logic [1:0]       cfg_q;
    logic             run_q, ch_err_q, ch_err_d, acc, kept, is_r, push, full, empty;
    logic             unused_bits;
    aud_pair_t        head;
    assign unused_bits       = ^{s_axis_aud_tdata[3:0], s_axis_aud_tdata[31:28]};
    assign s_axis_aud_tready = aud_en & run_q & ~full;
    assign acc  = s_axis_aud_tvalid & s_axis_aud_tready;
    assign kept = acc & (s_axis_aud_tid[2:1] == cfg_q);
    assign is_r = s_axis_aud_tid[TID_RIGHT_BIT];
    assign smp  = s_axis_aud_tdata[SMP_MSB:SMP_LSB];
`ifdef I2S_TX_10XE_PARITY_CHECK_EN
    logic par_bad, par_err_q;
    assign par_bad = ^s_axis_aud_tdata[PAR_BIT:SMP_LSB];
    assign smp_chk = par_bad ? '0 : smp;
    assign par_err = par_err_q;
    always_ff @(posedge s_axis_aud_aclk) begin
        par_err_q <= s_axis_aud_aresetn & kept & par_bad;
    end
`else
    assign smp_chk = smp;
    assign par_err = 1'b0;
`endif
    always_ff @(posedge s_axis_aud_aclk) begin
        state_q <= (!s_axis_aud_aresetn || !aud_en) ? WAIT_L : state_d;
    end
    always_comb begin
        state_d = kept ? (is_r ? WAIT_L : WAIT_R) : state_q;
    end
    always_comb begin
        push     = kept & is_r & (state_q == WAIT_R);
        ch_err_d = kept & (is_r == (state_q == WAIT_L));
        left_d   = (kept & ~is_r) ? smp_chk : left_q;
    end
    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            run_q    <= 1'b0;
            cfg_q    <= '0;
            left_q   <= '0;
            ch_err_q <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            cfg_q    <= aud_en ? cfg_q : cfg_pair;
            left_q   <= aud_en ? left_d : '0;
            ch_err_q <= ch_err_d;
        end
    end
    i2s_tx_10xe_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (s_axis_aud_aclk),
        .rstn_i  (s_axis_aud_aresetn),
        .flush_i (~aud_en),
        .push_i  (push),
        .pair_i  ('{l: left_q, r: smp_chk}),
        .pop_i   (smp_ready),
        .pair_o  (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );
    assign smp_valid = ~empty;
    assign smp_left  = head.l;
    assign smp_right = head.r;
    assign ch_err    = ch_err_q;
endmodule
